// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg -- op codes, FSM state encoding and default geometry shared by the
//             convolution RAM master and its address generator.
// Revision: 1.0
// ============================================================================
package conv_pkg;

  localparam logic [1:0] OP_KERN = 2'b00;
  localparam logic [1:0] OP_WIN  = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_KERN_BASE = 0;
  localparam int DEF_IMG_BASE  = 9;
  localparam int DEF_IMG_W     = 32;
  localparam int DEF_IMG_H     = 32;
  localparam int DEF_RES_BASE  = 2048;

  localparam logic [3:0] LAST_K = 4'd8;

  // Row-major 3x3 element index k = 3*kr + kc, split back into kr / kc.
  function automatic logic [1:0] elem_row(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: elem_row = 2'd0;
      4'd3, 4'd4, 4'd5: elem_row = 2'd1;
      4'd6, 4'd7, 4'd8: elem_row = 2'd2;
      default:          elem_row = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] elem_col(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: elem_col = 2'd0;
      4'd1, 4'd4, 4'd7: elem_col = 2'd1;
      4'd2, 4'd5, 4'd8: elem_col = 2'd2;
      default:          elem_col = 2'd0;
    endcase
  endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// conv_addr_gen -- combinational RAM address and range check for one element
//                  of a kernel load, window fetch or result write.
// Revision: 1.0
// ============================================================================
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int KERN_BASE = DEF_KERN_BASE,
  parameter int IMG_BASE  = DEF_IMG_BASE,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int RES_BASE  = DEF_RES_BASE
) (
  input  logic [1:0]        op,
  input  logic [5:0]        row,
  input  logic [5:0]        col,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic              range_ok
);

  // Two guard bits keep intermediate sums exact before truncation.
  localparam int AW2 = ADDR_W + 2;

  localparam logic [AW2-1:0] C_KERN_BASE  = AW2'(KERN_BASE);
  localparam logic [AW2-1:0] C_IMG_BASE   = AW2'(IMG_BASE);
  localparam logic [AW2-1:0] C_IMG_W      = AW2'(IMG_W);
  localparam logic [AW2-1:0] C_RES_BASE   = AW2'(RES_BASE);
  localparam logic [AW2-1:0] C_RES_STRIDE = AW2'(IMG_W - 2);
  localparam logic [AW2-1:0] C_ROW_MAX    = AW2'(IMG_H - 3);
  localparam logic [AW2-1:0] C_COL_MAX    = AW2'(IMG_W - 3);

  logic [AW2-1:0] row_x;
  logic [AW2-1:0] col_x;
  logic [AW2-1:0] kr_x;
  logic [AW2-1:0] kc_x;
  logic [AW2-1:0] k_x;
  logic [AW2-1:0] full_addr;
  logic           pos_ok;

  assign row_x  = AW2'(row);
  assign col_x  = AW2'(col);
  assign kr_x   = AW2'(elem_row(k));
  assign kc_x   = AW2'(elem_col(k));
  assign k_x    = AW2'(k);
  assign pos_ok = (row_x <= C_ROW_MAX) && (col_x <= C_COL_MAX);

  always_comb begin
    full_addr = '0;
    range_ok  = 1'b0;
    case (op)
      OP_KERN: begin
        full_addr = C_KERN_BASE + k_x;
        range_ok  = 1'b1;
      end
      OP_WIN: begin
        full_addr = C_IMG_BASE + (row_x + kr_x) * C_IMG_W + (col_x + kc_x);
        range_ok  = pos_ok;
      end
      OP_WR: begin
        full_addr = C_RES_BASE + row_x * C_RES_STRIDE + col_x;
        range_ok  = pos_ok;
      end
      default: begin
        full_addr = '0;
        range_ok  = 1'b0;
      end
    endcase
  end

  assign addr = ADDR_W'(full_addr);

endmodule : conv_addr_gen
`default_nettype wire

// File: rtl/conv_ram_master.sv
`default_nettype none
// ============================================================================
// conv_ram_master -- sequences kernel loads, 3x3 window fetches and result
//                    writes on a single-port RAM with one-cycle read latency.
// Revision: 1.0
// ============================================================================
module conv_ram_master
  import conv_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int KERN_BASE = DEF_KERN_BASE,
  parameter int IMG_BASE  = DEF_IMG_BASE,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int RES_BASE  = DEF_RES_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [5:0]        cmd_row,
  input  logic [5:0]        cmd_col,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        rd_idx,
  output logic              rd_last,
  output logic              rd_kern,
  output logic              err,
  output logic              ram_w_en,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state;
  logic [1:0]        op_q;
  logic [5:0]        row_q;
  logic [5:0]        col_q;
  logic [3:0]        cnt;
  logic              accept;

  logic [1:0]        ag_op;
  logic [5:0]        ag_row;
  logic [5:0]        ag_col;
  logic [3:0]        ag_k;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_ok;

  assign accept = cmd_valid && cmd_ready;

  // In IDLE the generator sees the offered command (validation plus element 0
  // address); while reading it looks one element ahead of the issued one.
  always_comb begin
    ag_op  = op_q;
    ag_row = row_q;
    ag_col = col_q;
    ag_k   = cnt + 4'd1;
    if (state == S_IDLE) begin
      ag_op  = cmd_op;
      ag_row = cmd_row;
      ag_col = cmd_col;
      ag_k   = 4'd0;
    end
  end

  conv_addr_gen #(
    .ADDR_W    (ADDR_W),
    .KERN_BASE (KERN_BASE),
    .IMG_BASE  (IMG_BASE),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .RES_BASE  (RES_BASE)
  ) u_addr_gen (
    .op       (ag_op),
    .row      (ag_row),
    .col      (ag_col),
    .k        (ag_k),
    .addr     (ag_addr),
    .range_ok (ag_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      op_q      <= OP_KERN;
      row_q     <= '0;
      col_q     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      ram_w_en  <= 1'b0;
      ram_r_en  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            row_q     <= cmd_row;
            col_q     <= cmd_col;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            if (!ag_ok) begin
              // Rejected commands borrow DRAIN as their single busy cycle.
              err   <= 1'b1;
              state <= S_DRAIN;
            end else if (cmd_op == OP_WR) begin
              state     <= S_WRITE;
              ram_w_en  <= 1'b1;
              ram_addr  <= ag_addr;
              ram_wdata <= cmd_wdata;
            end else begin
              state    <= S_READ;
              ram_r_en <= 1'b1;
              ram_addr <= ag_addr;
            end
          end
        end
        S_READ: begin
          if (cnt == LAST_K) begin
            state    <= S_DRAIN;
            ram_r_en <= 1'b0;
            ram_addr <= '0;
          end else begin
            cnt      <= cnt + 4'd1;
            ram_addr <= ag_addr;
          end
        end
        S_DRAIN: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        S_WRITE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          ram_w_en  <= 1'b0;
          ram_addr  <= '0;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          ram_w_en  <= 1'b0;
          ram_r_en  <= 1'b0;
        end
      endcase
    end
  end

  // Return pipeline: tags the read issued this cycle so it lines up with the
  // RAM's data one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      rd_kern  <= 1'b0;
    end else begin
      rd_valid <= ram_r_en;
      rd_idx   <= ram_r_en ? cnt : 4'd0;
      rd_kern  <= ram_r_en && (op_q == OP_KERN);
    end
  end

  assign rd_data = ram_rdata;
  assign rd_last = rd_valid && (rd_idx == LAST_K);

endmodule : conv_ram_master
`default_nettype wire

// File: tb/tb_conv_ram_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_conv_ram_master -- directed bench with a behavioural one-cycle-latency
//                       RAM; expected bytes come from the bench's own tables.
// Revision: 1.0
// ============================================================================
module tb_conv_ram_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_row;
  logic [5:0]  cmd_col;
  logic [7:0]  cmd_wdata;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [3:0]  rd_idx;
  logic        rd_last;
  logic        rd_kern;
  logic        err;
  logic        ram_w_en;
  logic        ram_r_en;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  int   total = 0;
  int   bad   = 0;
  logic excl_viol = 1'b0;

  logic [7:0] mem [0:4095];
  logic [7:0] kern_tab [0:8] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4,
                                 8'hD8, 8'hD7, 8'hD6, 8'hFF};

  always #5 clk = ~clk;

  conv_ram_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_wdata (cmd_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx),
    .rd_last   (rd_last),
    .rd_kern   (rd_kern),
    .err       (err),
    .ram_w_en  (ram_w_en),
    .ram_r_en  (ram_r_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_wdata;
    if (ram_r_en) ram_rdata <= mem[ram_addr];
    if (ram_w_en && ram_r_en) excl_viol <= 1'b1;
  end

  function automatic logic [7:0] img_px(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic int exp_addr(input int op, input int row, input int col, input int k);
    if (op == 0) return k;
    return 9 + (row + k / 3) * 32 + col + (k % 3);
  endfunction

  function automatic logic [7:0] exp_byte(input int a);
    if (a < 9) return kern_tab[a];
    return img_px(a - 9);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers a read command in the current cycle and checks T+1..T+11.
  task automatic read_cmd(input int op, input int row, input int col);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_row   = 6'(row);
    cmd_col   = 6'(col);
    check($sformatf("rd op%0d r%0d c%0d ready_T", op, row, col), cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("rd c%0d r_en", c), ram_r_en, (c <= 9) ? 1 : 0);
      check($sformatf("rd c%0d w_en", c), ram_w_en, 0);
      if (c <= 9)
        check($sformatf("rd c%0d addr", c), ram_addr, exp_addr(op, row, col, c - 1));
      if (c >= 2 && c <= 10) begin
        check($sformatf("rd c%0d valid", c), rd_valid, 1);
        check($sformatf("rd c%0d idx", c), rd_idx, c - 2);
        check($sformatf("rd c%0d data", c), rd_data, exp_byte(exp_addr(op, row, col, c - 2)));
        check($sformatf("rd c%0d last", c), rd_last, (c == 10) ? 1 : 0);
        check($sformatf("rd c%0d kern", c), rd_kern, (op == 0) ? 1 : 0);
      end else begin
        check($sformatf("rd c%0d valid", c), rd_valid, 0);
      end
      check($sformatf("rd c%0d ready", c), cmd_ready, (c == 11) ? 1 : 0);
      check($sformatf("rd c%0d err", c), err, 0);
      if (c < 11) @(negedge clk);
    end
  endtask

  task automatic err_cmd(input int op, input int row, input int col);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_row   = 6'(row);
    cmd_col   = 6'(col);
    check($sformatf("er op%0d ready_T", op), cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check($sformatf("er op%0d r%0d c%0d err", op, row, col), err, 1);
    check("er T1 ready", cmd_ready, 0);
    check("er T1 r_en", ram_r_en, 0);
    check("er T1 w_en", ram_w_en, 0);
    @(negedge clk);
    check("er T2 err", err, 0);
    check("er T2 ready", cmd_ready, 1);
    check("er T2 r_en", ram_r_en, 0);
    check("er T2 rd_valid", rd_valid, 0);
  endtask

  task automatic write_cmd(input int row, input int col, input logic [7:0] b, input int a);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_row   = 6'(row);
    cmd_col   = 6'(col);
    cmd_wdata = b;
    check("wr ready_T", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wr T1 w_en", ram_w_en, 1);
    check("wr T1 r_en", ram_r_en, 0);
    check("wr T1 addr", ram_addr, a);
    check("wr T1 wdata", ram_wdata, b);
    check("wr T1 ready", cmd_ready, 0);
    @(negedge clk);
    check("wr T2 w_en", ram_w_en, 0);
    check("wr T2 ready", cmd_ready, 1);
    check("wr readback", mem[a], b);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 9; i++) mem[i] = kern_tab[i];
    for (int i = 0; i < 1024; i++) mem[9 + i] = img_px(i);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_row   = 6'd0;
    cmd_col   = 6'd0;
    cmd_wdata = 8'h00;

    repeat (2) @(negedge clk);
    check("rst ready", cmd_ready, 1);
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_idx", rd_idx, 0);
    check("rst rd_last", rd_last, 0);
    check("rst rd_kern", rd_kern, 0);
    check("rst err", err, 0);
    check("rst w_en", ram_w_en, 0);
    check("rst r_en", ram_r_en, 0);
    check("rst addr", ram_addr, 0);
    check("rst wdata", ram_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    read_cmd(0, 0, 0);
    read_cmd(1, 0, 0);
    read_cmd(1, 29, 29);
    err_cmd(1, 30, 0);
    err_cmd(1, 0, 30);
    err_cmd(3, 0, 0);
    err_cmd(2, 0, 30);
    write_cmd(2, 3, 8'h5A, 2111);
    read_cmd(1, 2, 3);

    // Reset asserted at T+5 of a window fetch.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_row   = 6'd1;
    cmd_col   = 6'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid r_en before", ram_r_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid rst ready", cmd_ready, 1);
    check("mid rst rd_valid", rd_valid, 0);
    check("mid rst rd_idx", rd_idx, 0);
    check("mid rst r_en", ram_r_en, 0);
    check("mid rst w_en", ram_w_en, 0);
    check("mid rst addr", ram_addr, 0);
    check("mid rst wdata", ram_wdata, 0);
    check("mid rst err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post rst c%0d rd_valid", c), rd_valid, 0);
      check($sformatf("post rst c%0d r_en", c), ram_r_en, 0);
    end
    read_cmd(1, 5, 6);

    // Back-to-back: valid held, read then write.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_row   = 6'd0;
    cmd_col   = 6'd5;
    check("b2b ready_T", cmd_ready, 1);
    @(negedge clk);
    cmd_op    = 2'b10;
    cmd_row   = 6'd4;
    cmd_col   = 6'd7;
    cmd_wdata = 8'hA5;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("b2b c%0d ready", c), cmd_ready, 0);
      check($sformatf("b2b c%0d w_en", c), ram_w_en, 0);
      check($sformatf("b2b c%0d r_en", c), ram_r_en, (c <= 9) ? 1 : 0);
      @(negedge clk);
    end
    check("b2b T11 ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b T12 w_en", ram_w_en, 1);
    check("b2b T12 addr", ram_addr, 2175);
    check("b2b T12 wdata", ram_wdata, 8'hA5);
    @(negedge clk);
    check("b2b T13 ready", cmd_ready, 1);
    check("b2b readback", mem[2175], 8'hA5);

    check("rw exclusive", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_conv_ram_master
`default_nettype wire

// File: doc/conv_ram_master.md
# conv_ram_master

Initiator on the single-port image RAM's `w_en`/`r_en`/`address`/`data_in`/`data_out` interface; the RAM returns read data one cycle after the request. Accepts commands from the convolution datapath:
- load the 3x3 kernel (words 0..8),
- fetch a 3x3 pixel window from the row-major image at word 9 upward,
- write one result byte to the result region.

It sequences the RAM requests, absorbs the one-cycle read latency and streams returned bytes out with index tags.

## Interface
Parameters:
- `ADDR_W`, 12, RAM address width
- `DATA_W`, 8, RAM data width
- `KERN_BASE`, 0, first kernel coefficient word
- `IMG_BASE`, 9, first image pixel word (row 0, col 0)
- `IMG_W`, 32, image width in pixels
- `IMG_H`, 32, image height in pixels
- `RES_BASE`, 2048, first result word; result row stride is IMG_W-2

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_op`  in  2  00 load kernel, 01 fetch window, 10 write result, 11 reserved
- `cmd_row`  in  6  window top-left row / result row
- `cmd_col`  in  6  window top-left col / result col
- `cmd_wdata`  in  DATA_W  result byte for op 10
- `rd_valid`  out  1  returned byte valid; no backpressure, consumer must accept
- `rd_data`  out  DATA_W  returned byte
- `rd_idx`  out  4  element index 0..8, row-major (k = 3*kr + kc)
- `rd_last`  out  1  with idx 8
- `rd_kern`  out  1  byte is a kernel coefficient (op 00)
- `err`  out  1  one-cycle pulse, command rejected
- `ram_w_en`  out  1  to RAM `w_en`
- `ram_r_en`  out  1  to RAM `r_en`
- `ram_addr`  out  ADDR_W  to RAM `address`
- `ram_wdata`  out  DATA_W  to RAM `data_in`
- `ram_rdata`  in  DATA_W  from RAM `data_out`

## Operation
- States: IDLE, READ, DRAIN, WRITE.
- IDLE: `cmd_ready`=1. The handshake `cmd_valid && cmd_ready` latches op, row, col and wdata.
- Validation happens at accept:
  - Op 01 requires row ≤ IMG_H-3 and col ≤ IMG_W-3.
  - Op 10 requires row ≤ IMG_H-3 and col ≤ IMG_W-3.
  - Op 11 is always invalid.
  - An invalid command pulses `err` next cycle, makes no RAM access and returns to IDLE.
- READ: issues one read per cycle for k = 0..8 (`ram_r_en`=1, `ram_addr` = element address). After k = 8 → DRAIN.
- Element addresses:
  - op 00: KERN_BASE + k
  - op 01: IMG_BASE + (row+kr)*IMG_W + (col+kc)
- DRAIN: one cycle, no request. Outputs the last byte, then → IDLE.
- Return pipeline: a one-stage valid/idx/kern register tracks each issued read. `rd_valid`/`rd_idx`/`rd_kern` are that register; `rd_data` = `ram_rdata` in the same cycle.
- WRITE: one cycle with `ram_w_en`=1, `ram_addr` = RES_BASE + row*(IMG_W-2) + col, `ram_wdata` = latched byte. Then → IDLE.
- `ram_w_en` and `ram_r_en` are never high together.
- Address arithmetic is done at ADDR_W+2 bits and truncated to ADDR_W. Valid parameters never overflow.
- Reset (any state, any time): state IDLE; return pipeline cleared. Read data the RAM returns after reset is ignored (`rd_valid`=0).

## Timing
- Reset values: `cmd_ready`=1, `rd_valid`=0, `rd_data` follows `ram_rdata` (don't-care), `rd_idx`=0, `rd_last`=0, `rd_kern`=0, `err`=0, `ram_w_en`=0, `ram_r_en`=0, `ram_addr`=0, `ram_wdata`=0.
- Read command (op 00/01) accepted at cycle T:
  - `ram_r_en` high T+1..T+9
  - `rd_valid` high T+2..T+10; `rd_last` at T+10
  - `cmd_ready` high again T+11
- Write command accepted at T: `ram_w_en` at T+1; `cmd_ready` at T+2.
- Rejected command accepted at T: `err` at T+1; `cmd_ready` at T+2.
- Commands are never accepted outside IDLE. `cmd_valid` held high while busy is accepted at the first IDLE cycle.
- RAM control outputs are registered (driven from state and counter flops).

## Structure
- `conv_pkg` holds:
  - op code constants (OP_KERN, OP_WIN, OP_WR, OP_RSV)
  - state enum
  - default parameter values KERN_BASE, IMG_BASE, IMG_W, IMG_H, RES_BASE
- Sub-module `conv_addr_gen`: combinational; takes (op, row, col, k) and returns the RAM address plus a range-valid flag. It isolates all address arithmetic.
- Top level holds the FSM, 4-bit element counter, command latch and return pipeline register.

## Test plan
- Reset, op 00: RAM preloaded 0xD0..0xD4, 0xD8, 0xD7, 0xD6, 0xFF at words 0..8 → `rd_kern`=1, bytes in that order with idx 0..8, `rd_last` at idx 8, `cmd_ready` at T+11.
- Op 01, row 0, col 0 → addresses 9, 10, 11, 41, 42, 43, 73, 74, 75 on T+1..T+9; data matches image file values.
- Op 01, row 29, col 29 (last legal) → last address 9 + 31*32 + 31 = 1032; op 01, row 30 → `err` pulse, no `ram_r_en`.
- Op 10, row 2, col 3, wdata 0x5A → single `ram_w_en` at address 2048 + 60 + 3 = 2111; a following op 01 at 2111's neighbourhood is unaffected; reading 2111 back via bench returns 0x5A.
- `rst_n` asserted at T+5 of a window fetch → all outputs at reset values immediately; no `rd_valid` after release; next command accepted normally.
- Back-to-back: `cmd_valid` held with op 01, then op 10 → second accepted exactly at T+11; `ram_w_en`/`ram_r_en` never simultaneously high (assertion).
